// File: rtl/pc_unit_p.sv
// pc_unit_p: MIPS fetch-stage program counter.
// Handles sequential, branch, jump and register-jump sequencing, plus stall hold,
// exception redirect and a circular return-address stack (RAS) for call/return
// tracking. The registered PC (inst) addresses instruction memory.
module pc_unit_p #(
    parameter int          WIDTH        = 32,
    parameter logic [63:0] RESET_VECTOR = 64'h0,
    parameter logic [63:0] EXC_VECTOR   = 64'h8000_0180,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         exc,
    input  logic                         branch,
    input  logic                         bne,
    input  logic                         zero,
    input  logic                         jump,
    input  logic                         jr,
    input  logic                         link,
    input  logic [25:0]                  target_inst,
    input  logic [WIDTH-1:0]             seIn,
    input  logic [WIDTH-1:0]             reg_Da,
    output logic [WIDTH-1:0]             inst,
    output logic [WIDTH-1:0]             pc_plus4,
    output logic [WIDTH-1:0]             ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [WIDTH-1:0] RST_PC   = RESET_VECTOR[WIDTH-1:0];
    localparam logic [WIDTH-1:0] EXC_PC   = EXC_VECTOR[WIDTH-1:0];
    localparam logic [WIDTH-1:0] JR_MASK  = {{(WIDTH-2){1'b1}}, 2'b00};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // RAS operation selected for this cycle
    typedef enum logic [1:0] {
        RAS_NONE,
        RAS_PUSH,
        RAS_POP,
        RAS_REPL
    } ras_op_e;

    // Decoded per-cycle control
    typedef struct packed {
        logic    redirect;  // exception redirect
        logic    hold;      // stall without exception
        logic    br_taken;  // conditional branch resolves taken
        ras_op_e ras_op;
    } pc_ctl_t;

    pc_ctl_t ctl;

    logic [WIDTH-1:0]                pc_nxt;
    logic [WIDTH-1:0]                br_tgt;
    logic [WIDTH-1:0]                jmp_tgt;
    logic [WIDTH-1:0]                jr_tgt;

    logic [RAS_DEPTH-1:0][WIDTH-1:0] ras_q;
    logic [PTR_W-1:0]                ptr_q;
    logic [PTR_W-1:0]                top_idx;
    logic [CNT_W-1:0]                cnt_q;
    logic                            ras_empty;

    // Candidate targets; all sums wrap modulo 2^WIDTH
    assign pc_plus4 = inst + WIDTH'(4);
    assign br_tgt   = pc_plus4 + (seIn << 2);
    assign jmp_tgt  = {pc_plus4[WIDTH-1:28], target_inst, 2'b00};
    assign jr_tgt   = reg_Da & JR_MASK;

    // Top of stack sits one below the write pointer (wraps naturally)
    assign top_idx   = ptr_q - PTR_ONE;
    assign ras_empty = (cnt_q == '0);

    // Decode control inputs: exception beats stall, stall blocks everything else
    always_comb begin
        ctl          = '0;
        ctl.ras_op   = RAS_NONE;
        ctl.redirect = exc;
        ctl.hold     = stall & ~exc;
        ctl.br_taken = branch & (zero ^ bne);
        if (!exc && !stall) begin
            if (jr) begin
                // JALR on an empty stack has nothing to replace, so it pushes
                if (link) ctl.ras_op = ras_empty ? RAS_PUSH : RAS_REPL;
                else      ctl.ras_op = RAS_POP;
            end else if (jump && link) begin
                ctl.ras_op = RAS_PUSH;
            end
        end
    end

    // Next-PC priority: exc > stall > jr > jump > taken branch > sequential
    always_comb begin
        pc_nxt = pc_plus4;
        if (ctl.redirect)      pc_nxt = EXC_PC;
        else if (ctl.hold)     pc_nxt = inst;
        else if (jr)           pc_nxt = jr_tgt;
        else if (jump)         pc_nxt = jmp_tgt;
        else if (ctl.br_taken) pc_nxt = br_tgt;
    end

    // PC register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) inst <= RST_PC;
        else      inst <= pc_nxt;
    end

    // Circular return-address stack; a push while full overwrites the oldest slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ras_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            case (ctl.ras_op)
                RAS_PUSH: begin
                    ras_q[ptr_q] <= pc_plus4;
                    ptr_q        <= ptr_q + PTR_ONE;
                    if (cnt_q == CNT_FULL) ras_ovf <= 1'b1;
                    else                   cnt_q   <= cnt_q + CNT_ONE;
                end
                RAS_POP: begin
                    if (!ras_empty) begin
                        ptr_q <= ptr_q - PTR_ONE;
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        ras_unf <= 1'b1;
                    end
                end
                RAS_REPL: ras_q[top_idx] <= pc_plus4;
                default: ;
            endcase
        end
    end

    assign ras_top   = ras_empty ? '0 : ras_q[top_idx];
    assign ras_count = cnt_q;

endmodule

// File: tb/tb_pc_unit_p.sv
// tb_pc_unit_p: directed walk through the fetch-PC scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_pc_unit_p;

    localparam int          W   = 32;
    localparam int          D   = 4;
    localparam logic [31:0] EXC = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall, exc, branch, bne, zero, jump, jr, link;
    logic [25:0] target_inst;
    logic [W-1:0] seIn, reg_Da;
    logic [W-1:0] inst, pc_plus4, ras_top;
    logic [$clog2(D):0] ras_count;
    logic        ras_ovf, ras_unf;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_ovf, m_unf;

    int errors = 0;
    int checks = 0;

    pc_unit_p #(.WIDTH(W), .RAS_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .stall(stall), .exc(exc), .branch(branch),
        .bne(bne), .zero(zero), .jump(jump), .jr(jr), .link(link),
        .target_inst(target_inst), .seIn(seIn), .reg_Da(reg_Da),
        .inst(inst), .pc_plus4(pc_plus4), .ras_top(ras_top),
        .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] e4, etop;
        e4   = m_pc + 32'd4;
        etop = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'd0;
        chk({tag, ".inst"}, inst, m_pc);
        chk({tag, ".pc_plus4"}, pc_plus4, e4);
        chk({tag, ".ras_top"}, ras_top, etop);
        chk({tag, ".ras_count"}, ras_count, m_ras.size());
        chk({tag, ".ras_ovf"}, ras_ovf, m_ovf);
        chk({tag, ".ras_unf"}, ras_unf, m_unf);
    endtask

    task automatic model_reset();
        m_pc  = 32'd0;
        m_ras.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic ras_push(input logic [31:0] v);
        if (m_ras.size() == D) begin
            m_ras.delete(0);
            m_ovf = 1'b1;
        end
        m_ras.push_back(v);
    endtask

    // One clock of the architectural rules, applied to the current inputs
    task automatic model_step();
        logic [31:0] pc4;
        pc4 = m_pc + 32'd4;
        if (exc) begin
            m_pc = EXC;
        end else if (!stall) begin
            if (jr) begin
                if (link) begin
                    if (m_ras.size() > 0) m_ras[m_ras.size()-1] = pc4;
                    else                  ras_push(pc4);
                end else if (m_ras.size() > 0) begin
                    m_ras.delete(m_ras.size()-1);
                end else begin
                    m_unf = 1'b1;
                end
            end else if (jump && link) begin
                ras_push(pc4);
            end
            if (jr)                         m_pc = {reg_Da[31:2], 2'b00};
            else if (jump)                  m_pc = {pc4[31:28], target_inst, 2'b00};
            else if (branch && (zero != bne)) m_pc = pc4 + (seIn << 2);
            else                            m_pc = pc4;
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic clear_ctl();
        stall = 0; exc = 0; branch = 0; bne = 0; zero = 0;
        jump = 0; jr = 0; link = 0;
        target_inst = '0; seIn = '0; reg_Da = '0;
    endtask

    initial begin
        clear_ctl();
        model_reset();
        rst = 1'b0;

        // Reset then free-run
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;
        tick("run4");
        tick("run8");
        tick("run12");
        tick("run16");
        chk("at_0x10", inst, 32'h10);

        // Branches
        branch = 1; zero = 1; bne = 0; seIn = 32'd3;
        tick("beq_taken");
        chk("beq_tgt", inst, 32'h20);
        seIn = 32'hFFFF_FFFB;
        tick("beq_back");
        bne = 1;
        seIn = 32'd3;
        tick("bne_not_taken");
        chk("bne_nt_tgt", inst, 32'h14);
        bne = 0;
        seIn = 32'h0400_000A;
        tick("far_branch");
        chk("far_tgt", inst, 32'h1000_0040);

        // Jump-and-link then return
        branch = 0; jump = 1; link = 1; target_inst = 26'h100;
        tick("jal");
        chk("jal_tgt", inst, 32'h1000_0400);
        chk("jal_ret", ras_top, 32'h1000_0044);
        chk("jal_cnt", ras_count, 1);
        jump = 0; link = 0; jr = 1; reg_Da = 32'h1000_0047;
        tick("jr_ret");
        chk("jr_tgt", inst, 32'h1000_0044);
        chk("jr_cnt", ras_count, 0);

        // Reach 0x8, then stall (other controls must be ignored), then exc over stall
        jr = 0; branch = 1; zero = 1; seIn = 32'hFBFF_FFF0;
        tick("br_to_8");
        chk("at_0x8", inst, 32'h8);
        stall = 1; jump = 1; link = 1; target_inst = 26'h3;
        repeat (3) tick("stall");
        chk("stall_hold", inst, 32'h8);
        chk("stall_ras", ras_count, 0);
        exc = 1;
        tick("exc_over_stall");
        chk("exc_tgt", inst, EXC);
        chk("exc_ras", ras_count, 0);

        // Five calls overflow a four-deep stack
        clear_ctl();
        for (int i = 0; i < 5; i++) begin
            jump = 1; link = 1; target_inst = 26'h100 + 26'(i);
            tick("jal_wrap");
        end
        chk("wrap_cnt", ras_count, 4);
        chk("wrap_ovf", ras_ovf, 1'b1);
        chk("wrap_top", ras_top, 32'h8000_0410);

        // Five returns: four pops, fifth underflows
        clear_ctl();
        jr = 1;
        for (int i = 0; i < 4; i++) begin
            reg_Da = 32'h100 + 32'(i * 8) + 32'd3;
            tick("jr_pop");
        end
        chk("pop_cnt", ras_count, 0);
        chk("pop_unf_clear", ras_unf, 1'b0);
        reg_Da = 32'h2C;
        tick("jr_unf");
        chk("unf_set", ras_unf, 1'b1);
        chk("unf_cnt", ras_count, 0);

        // Async reset in the middle of a stalled cycle
        clear_ctl();
        tick("to_0x30");
        chk("at_0x30", inst, 32'h30);
        stall = 1;
        tick("stall_30");
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("arst_inst", inst, 32'h0);
        chk("arst_ovf", ras_ovf, 1'b0);
        chk("arst_unf", ras_unf, 1'b0);
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst = 1'b1;
        stall = 0;
        tick("rst_release");

        // Randomized run
        for (int n = 0; n < 400; n++) begin
            stall       = ($urandom_range(0, 7) == 0);
            exc         = ($urandom_range(0, 15) == 0);
            branch      = 1'($urandom_range(0, 1));
            bne         = 1'($urandom_range(0, 1));
            zero        = 1'($urandom_range(0, 1));
            jump        = ($urandom_range(0, 3) == 0);
            jr          = ($urandom_range(0, 3) == 0);
            link        = 1'($urandom_range(0, 1));
            target_inst = 26'($urandom);
            seIn        = 32'(int'($urandom_range(0, 63)) - 32);
            reg_Da      = $urandom;
            if ($urandom_range(0, 63) == 0) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                check_all("rnd_arst");
                @(posedge clk);
                #1;
                rst = 1'b1;
                check_all("rnd_arst_hold");
            end else begin
                tick("rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit_p.md
Name: pc_unit_p

Overview:
Parametrised next-generation program counter for the MIPS fetch stage. It adds the following on top of sequential, branch and jump sequencing:
- stall hold
- exception redirect
- register jumps with optional link (JR/JALR)
- a circular return-address stack (RAS) for call/return tracking

The registered PC drives instruction-memory addressing. RAS outputs feed the link/debug path.

Parameters:
WIDTH, 32, PC/data width in bits; legal 29..64
RESET_VECTOR, 0, PC value loaded on reset
EXC_VECTOR, 32'h80000180, PC loaded on exception (zero-extended/truncated to WIDTH)
RAS_DEPTH, 4, return-address stack entries; power of two, 2..16

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  hold PC and RAS this cycle
exc  in  1  exception redirect request
branch  in  1  conditional branch instruction in decode
bne  in  1  branch sense: 0 = taken on zero, 1 = taken on !zero
zero  in  1  ALU zero flag
jump  in  1  J/JAL instruction
jr  in  1  JR/JALR instruction
link  in  1  qualifies jump/jr as link (JAL/JALR)
target_inst  in  26  J-format target field
seIn  in  WIDTH  sign-extended branch offset (words)
reg_Da  in  WIDTH  register operand for jr
inst  out  WIDTH  current PC (registered)
pc_plus4  out  WIDTH  inst+4 (combinational)
ras_top  out  WIDTH  top RAS entry; 0 when empty
ras_count  out  $clog2(RAS_DEPTH)+1  valid entries
ras_ovf  out  1  sticky: push occurred while full
ras_unf  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (rst=0, asynchronous):
  - inst=RESET_VECTOR
  - RAS entries, pointer, ras_count, ras_ovf and ras_unf all 0
  - Release is synchronous to clk. The first update occurs on the first rising edge with rst=1.
- Arithmetic: all addition is modulo 2^WIDTH.
  - pc_plus4 = inst+4
  - branch target = pc_plus4 + (seIn<<2)
  - jump target = {pc_plus4[WIDTH-1:28], target_inst, 2'b00}
  - jr target = {reg_Da[WIDTH-1:2], 2'b00}. Low bits are discarded and inst[1:0] is always 0.
- Next-PC priority, evaluated each rising edge (highest first):
  1. exc: inst<=EXC_VECTOR. Overrides stall. RAS untouched.
  2. stall: inst and RAS hold. All control inputs are ignored.
  3. jr: inst<=jr target.
  4. jump: inst<=jump target.
  5. branch & (zero ^ bne): inst<=branch target.
  6. otherwise: inst<=pc_plus4. This includes branch not taken.
- Single-cycle latency: the PC decision made at edge N is visible on inst after edge N.
- RAS updates happen only when neither exc nor stall is active.
  - Push (jump&link, jr=0): entry[ptr]<=pc_plus4, ptr<=ptr+1 mod RAS_DEPTH, count<=min(count+1, RAS_DEPTH).
  - Push when count=RAS_DEPTH: the oldest entry is overwritten (circular wrap), count stays at RAS_DEPTH, ras_ovf<=1.
  - Pop (jr & !link): if count>0, ptr<=ptr-1 and count<=count-1. If count=0, no change and ras_unf<=1.
  - Replace (jr & link, JALR):
    - If count>0: top entry<=pc_plus4, ptr and count unchanged.
    - If count=0: behaves as a push.
  - jump & jr together: jr wins for the PC. The RAS follows the jr rules.
- Outputs:
  - ras_top = entry[ptr-1] when count>0, else 0.
  - ras_ovf and ras_unf clear only on reset.
- Reset mid-operation (including during stall or exc) takes effect immediately. No pending state survives.

Test Plan:
1. Reset then free-run: rst=0 for 2 cycles, then 1, all controls 0 → inst=0,4,8,12 on successive edges; ras_count=0.
2. Branch: at inst=0x10, branch=1, zero=1, bne=0, seIn=3 → inst=0x20. Repeat with bne=1, zero=1 → inst=0x14.
3. Jump and link: at inst=0x1000_0040, jump=1, link=1, target_inst=0x0000100 → inst=0x1000_0400, ras_top=0x1000_0044, ras_count=1. Then jr=1, reg_Da=0x1000_0047 → inst=0x1000_0044, ras_count=0.
4. Stall vs exception: stall=1 for 3 cycles at inst=0x8 → inst stays 0x8. Then stall=1 and exc=1 → inst=0x80000180, RAS unchanged.
5. RAS wrap (RAS_DEPTH=4): 5 consecutive JALs → ras_count=4, ras_ovf=1, ras_top=the fifth return address. Then 5 JRs → 4 pops, and the fifth pop sets ras_unf=1 with ras_count=0.
6. Async reset mid-stall: assert rst=0 between clock edges while stall=1 and inst=0x30 → inst=RESET_VECTOR before the next edge; flags clear.
